// File: rtl/timer_consumer_pkg.sv
// Types and defaults shared by the GALS timer producer/consumer pair.
package timer_consumer_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_CAPTURE = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/timer_consumer_sync_ff.sv
// N-stage flip-flop synchronizer for single-bit (or gray-safe) signals
// crossing into the clk domain.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/timer_consumer.sv
// Consumer end of the GALS timer pair: four-phase t_en/t_valid handshake,
// stable capture of t_out, and a small FIFO towards a ready/valid sink.
module timer_consumer
    import timer_consumer_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clock_2,
    input  logic              reset,
    input  logic              t_valid,
    input  logic [DATA_W-1:0] t_out,
    output logic              t_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              fifo_full,
    output logic [15:0]       rx_count,
    output logic              err_timeout
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    fsm_state_e        state_q, state_d;
    logic              t_en_q, t_en_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              err_q, err_d;
    logic [15:0]       rx_count_q, rx_count_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic              v_sync;
    logic              push, pop, empty, full;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_valid_sync (
        .clk   (clock_2),
        .rst_n (reset),
        .d_i   (t_valid),
        .q_o   (v_sync)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop   = !empty && data_ready;

    assign wait_inc = wait_q + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!full) begin
                    state_d = ST_REQ;
                    wait_d  = '0;
                end
            end
            ST_REQ: begin
                wait_d = wait_inc;
                if (v_sync) begin
                    state_d = ST_RELEASE;
                end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_RELEASE: begin
                // v_sync low proves the producer has frozen t_out.
                if (!v_sync) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        t_en_d = (state_d == ST_REQ);
    end

    assign rx_count_d = rx_count_q + 16'(push);

    always_ff @(posedge clock_2 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            t_en_q     <= 1'b0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            rx_count_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            t_en_q     <= t_en_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            rx_count_q <= rx_count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the empty flag masks stale contents, so resetting it buys nothing.
    always_ff @(posedge clock_2) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= t_out;
        end
    end

    assign t_en        = t_en_q;
    assign data_valid  = !empty;
    assign data_out    = empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign fifo_full   = full;
    assign rx_count    = rx_count_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_timer_consumer.sv
// Self-checking bench for timer_consumer: async producer model, queue scoreboard,
// table-driven fill phases and directed handshake corner cases.
`timescale 1ns/1ps
module tb_timer_consumer;
    import timer_consumer_pkg::*;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic              clock_2    = 1'b0;
    logic              reset      = 1'b0;
    logic              t_valid    = 1'b0;
    logic [DATA_W-1:0] t_out      = '0;
    logic              data_ready = 1'b0;
    logic              t_en, data_valid, fifo_full, err_timeout;
    logic [DATA_W-1:0] data_out;
    logic [15:0]       rx_count;

    logic prod_clk = 1'b0;
    always #5 clock_2  = ~clock_2;
    always #3 prod_clk = ~prod_clk;

    timer_consumer #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clock_2     (clock_2),
        .reset       (reset),
        .t_valid     (t_valid),
        .t_out       (t_out),
        .t_en        (t_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .fifo_full   (fifo_full),
        .rx_count    (rx_count),
        .err_timeout (err_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer model: answers each request with the next word 0,1,2,..., or
    // replays its held word when the bench says the consumer was reset mid-handshake.
    bit          prod_en    = 1'b0;
    int          replay_req = 0;
    int          replay_ack = 0;
    logic [1:0]  ten_sync   = '0;
    logic [15:0] next_word  = '0;

    always @(posedge prod_clk) begin
        ten_sync <= {ten_sync[0], t_en};
        if (!prod_en) begin
            t_valid <= 1'b0;
        end else if (ten_sync[1] && !t_valid) begin
            if (replay_req != replay_ack) begin
                replay_ack <= replay_req;
            end else begin
                t_out     <= next_word;
                next_word <= next_word + 16'd1;
            end
            t_valid <= 1'b1;
        end else if (!ten_sync[1] && t_valid) begin
            t_valid <= 1'b0;
        end
    end

    // Scoreboard: a word is owed to the sink for every t_en fall that follows a
    // live request; reset discards everything owed.
    logic [15:0] exp_q[$];
    logic [15:0] popped[$];
    bit          mon_en    = 1'b0;
    logic        ten_prev  = 1'b0;
    int          last_word = -1;

    always begin
        @(negedge clock_2);
        #2;
        if (!reset) begin
            exp_q.delete();
            popped.delete();
            last_word = -1;
            ten_prev  = 1'b0;
        end else begin
            if (data_valid && data_ready) begin
                check("pop_has_model", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("pop_word", 32'(data_out), 32'(exp_q.pop_front()));
                    if (last_word >= 0)
                        check("pop_increasing", 32'(int'(data_out) > last_word), 32'd1);
                    last_word = int'(data_out);
                    popped.push_back(data_out);
                end
            end
            if (mon_en && ten_prev && !t_en) exp_q.push_back(t_out);
            ten_prev = t_en;
        end
    end

    task automatic wait_neg();
        @(negedge clock_2);
        #1;
    endtask

    task automatic drain_then_stall();
        int n;
        data_ready = 1'b1;
        n = 0;
        while (data_valid && n < 500) begin wait_neg(); n++; end
        check("drain_empty", 32'(data_valid), 32'd0);
        data_ready = 1'b0;
    endtask

    typedef struct {
        int n_caps;
        bit exp_full;
        bit exp_valid;
    } fill_vec_t;

    fill_vec_t fill_tbl[4];

    initial begin
        int          n;
        logic [15:0] base, held, exp_next, exp_tail;
        logic [1:0]  tail_idx;

        fill_tbl[0] = '{1, 1'b0, 1'b1};
        fill_tbl[1] = '{2, 1'b0, 1'b1};
        fill_tbl[2] = '{3, 1'b0, 1'b1};
        fill_tbl[3] = '{4, 1'b1, 1'b1};

        // Reset state, then timeout with no producer.
        repeat (3) wait_neg();
        check("rst_t_en", 32'(t_en), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);

        reset = 1'b1;
        wait_neg();
        check("t_en_rise", 32'(t_en), 32'd1);
        n = 0;
        while (t_en && n < 1000) begin n++; wait_neg(); end
        check("req_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_err", 32'(err_timeout), 32'd1);
        check("timeout_idle", 32'(t_en), 32'd0);
        check("timeout_rx", 32'(rx_count), 32'd0);
        wait_neg();
        check("timeout_rereq", 32'(t_en), 32'd1);
        wait_neg();
        check("err_sticky", 32'(err_timeout), 32'd1);

        // Streaming with a live producer and an always-ready sink.
        reset = 1'b0;
        repeat (3) wait_neg();
        check("rst_clears_err", 32'(err_timeout), 32'd0);
        prod_en    = 1'b1;
        mon_en     = 1'b1;
        data_ready = 1'b1;
        reset      = 1'b1;
        n = 0;
        while (rx_count != 16'd8 && n < 3000) begin wait_neg(); n++; end
        check("rx_eight", 32'(rx_count), 32'd8);
        n = 0;
        while (popped.size() < 8 && n < 500) begin wait_neg(); n++; end
        check("popped_eight", 32'(popped.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < popped.size(); i++)
            check("stream_word", 32'(popped[i]), 32'(i));

        // Fill phases: stall the sink and count captures into an empty FIFO.
        for (int v = 0; v < 4; v++) begin
            drain_then_stall();
            base = rx_count;
            n = 0;
            while (16'(rx_count - base) != 16'(fill_tbl[v].n_caps) && n < 2000) begin
                wait_neg(); n++;
            end
            check("fill_count", 32'(16'(rx_count - base)), 32'(fill_tbl[v].n_caps));
            check("fill_full", 32'(fifo_full), 32'(fill_tbl[v].exp_full));
            check("fill_valid", 32'(data_valid), 32'(fill_tbl[v].exp_valid));
        end

        // Full FIFO holds the FSM in IDLE until a single pop frees a slot.
        n = 0;
        for (int c = 0; c < 40; c++) begin
            wait_neg();
            if (t_en) n++;
        end
        check("full_no_req", 32'(n), 32'd0);
        check("full_hold", 32'(fifo_full), 32'd1);
        data_ready = 1'b1;
        wait_neg();
        data_ready = 1'b0;
        check("pulse_unfull", 32'(fifo_full), 32'd0);
        n = 0;
        while (!t_en && n < 20) begin wait_neg(); n++; end
        check("pulse_req", 32'(t_en), 32'd1);
        n = 0;
        while (16'(rx_count - base) != 16'(DEPTH + 1) && n < 500) begin wait_neg(); n++; end
        check("fifth_word", 32'(16'(rx_count - base)), 32'(DEPTH + 1));
        check("fifth_full", 32'(fifo_full), 32'd1);

        // Push and pop on the same edge at occupancy 2.
        drain_then_stall();
        base = rx_count;
        n = 0;
        while (16'(rx_count - base) != 16'd2 && n < 1000) begin wait_neg(); n++; end
        n = 0;
        while (dut.state_q != ST_CAPTURE && n < 500) begin wait_neg(); n++; end
        check("cap_reached", 32'(dut.state_q == ST_CAPTURE), 32'd1);
        check("model_depth", 32'(exp_q.size()), 32'd3);
        exp_next = (exp_q.size() > 1) ? exp_q[1] : 16'hDEAD;
        exp_tail = (exp_q.size() > 2) ? exp_q[2] : 16'hDEAD;
        data_ready = 1'b1;
        wait_neg();
        data_ready = 1'b0;
        check("pp_occupancy", 32'(3'(dut.wr_ptr_q - dut.rd_ptr_q)), 32'd2);
        check("pp_head", 32'(data_out), 32'(exp_next));
        tail_idx = dut.wr_ptr_q[1:0] - 2'd1;
        check("pp_tail", 32'(dut.fifo_mem[tail_idx]), 32'(exp_tail));
        check("pp_not_full", 32'(fifo_full), 32'd0);

        // Reset while waiting in RELEASE: FIFO flushed, producer replays.
        n = 0;
        while (dut.state_q != ST_RELEASE && n < 500) begin wait_neg(); n++; end
        check("release_reached", 32'(dut.state_q == ST_RELEASE), 32'd1);
        held = t_out;
        reset = 1'b0;
        replay_req++;
        #1;
        check("mid_rst_t_en", 32'(t_en), 32'd0);
        check("mid_rst_empty", 32'(data_valid), 32'd0);
        check("mid_rst_full", 32'(fifo_full), 32'd0);
        repeat (3) wait_neg();
        reset = 1'b1;
        n = 0;
        while (rx_count != 16'd1 && n < 1000) begin wait_neg(); n++; end
        check("replay_count", 32'(rx_count), 32'd1);
        check("replay_word", 32'(data_out), 32'(held));

        // Random sink back-pressure against the scoreboard.
        for (int c = 0; c < 400; c++) begin
            data_ready = 1'($urandom_range(0, 1));
            wait_neg();
        end
        data_ready = 1'b1;

        // rx_count wrap from a preloaded 0xFFFF.
        n = 0;
        while (dut.state_q != ST_REQ && n < 500) begin wait_neg(); n++; end
        force dut.rx_count_d = 16'hFFFF;
        @(posedge clock_2);
        #1;
        release dut.rx_count_d;
        wait_neg();
        check("rx_preload", 32'(rx_count), 32'hFFFF);
        n = 0;
        while (rx_count == 16'hFFFF && n < 500) begin wait_neg(); n++; end
        check("rx_wrap", 32'(rx_count), 32'd0);
        check("no_timeout_live", 32'(err_timeout), 32'd0);

        repeat (20) wait_neg();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
